wave_bank_config: RTL and testbench
===================================

// Module: wave_bank_config
// PURPOSE
//   Configuration and timing controller for the 16-channel sine summing datapath.
//   - Host writes per-channel amplitude, offset, phaseword and rate divisor into a shadow bank over a valid/ready port.
//   - A commit request copies the shadow bank to the active outputs atomically, on a frame boundary.
//   - Generates the per-channel rate ticks (clks) and an optional datapath reset pulse.
// PARAMETERS
//   NCH  16  number of channels (index width fixed at 4 bits; NCH<=16)
//   W    16  width of each per-channel field
// PORTS
//   clk          in   1      system clock, all logic on rising edge
//   reset_n      in   1      asynchronous, active-low reset
//   wr_valid     in   1      host write request
//   wr_ready     out  1      controller accepts write this cycle
//   wr_chan      in   4      target channel index
//   wr_field     in   2      0=amp 1=offset 2=phaseword 3=divisor
//   wr_data      in   W      field value (amp is signed)
//   ch_enable    in   NCH    live per-channel enable mask (not banked)
//   commit_req   in   1      request shadow->active copy (pulse)
//   commit_resync in  1      sampled with commit_req; request datapath reset on commit
//   frame_tick   in   1      frame boundary strobe; commit happens only here
//   busy         out  1      commit pending or in progress
//   amps         out  NCH*W  active amplitudes, ch i at [i*W +: W]
//   offsets      out  NCH*W  active offsets
//   phasewords   out  NCH*W  active phasewords
//   clks         out  NCH    per-channel rate tick, 1-cycle pulses
//   dp_reset     out  1      1-cycle reset pulse to datapath after resync commit
// BEHAVIOUR
//   - Reset (reset_n=0, async)
//     - Shadow and active banks, divisors and counters all 0.
//     - clks=0, dp_reset=0, busy=0, wr_ready=1, FSM=IDLE.
//   - Write handshake: transfer when wr_valid&&wr_ready.
//     - The shadow field is updated at that edge; active outputs are untouched.
//     - wr_chan>=NCH: write accepted and discarded.
//     - wr_ready=1 only in IDLE; the host holds wr_valid until accepted.
//   - FSM IDLE -> PENDING on commit_req; commit_resync latched into resync_q.
//     - A write and commit_req in the same IDLE cycle: the write is applied first and is included in the commit.
//   - FSM PENDING: busy=1, wr_ready=0, further commit_req ignored.
//     - frame_tick -> COMMIT.
//     - A frame_tick coincident with the commit_req that entered PENDING does NOT count; wait for the next one.
//   - FSM COMMIT (1 cycle): busy=1.
//     - At the end of this cycle, all active fields and divisors <= shadow.
//     - All rate counters <= 0.
//     - Next state IDLE.
//     - dp_reset=1 in the cycle after COMMIT iff resync_q; otherwise 0.
//   - Rate ticks, per channel i, with active divisor d and counter cnt (W bits):
//     - ch_enable[i]=0: cnt held at 0, clks[i]=0.
//     - Otherwise: clks[i]=(cnt==d), registered. cnt<=(cnt==d)?0:cnt+1.
//     - Tick period is d+1 cycles; d=0 gives a tick every cycle.
//     - First tick arrives d+1 cycles after enable or commit.
//     - Counter never wraps past d; divisor change takes effect only via commit.
//   - Latency
//     - Write to visible output: write edge + PENDING wait + 1 cycle.
//     - Active outputs change only on the COMMIT edge, so the datapath never sees a partial bank.
//   - Reset mid-PENDING/COMMIT: commit abandoned, banks cleared, FSM IDLE.
// TESTING
//   1. Reset: reset_n low mid-run -> all outputs 0 immediately, wr_ready=1, busy=0.
//   2. Write amp ch3=0x7FFF, no commit -> amps[63:48] stays 0.
//      Then commit_req, frame_tick 5 cycles later -> amps[63:48]=0x7FFF one cycle after that tick.
//   3. Divisor ch0=3, enable ch0, commit -> clks[0] pulses every 4 cycles.
//      First pulse 4 cycles after COMMIT; ch_enable[0]=0 stops pulses next cycle.
//   4. Write and commit_req in same cycle, frame_tick same cycle -> value committed on the NEXT frame_tick.
//      wr_ready=0 and busy=1 until then.
//   5. Commit with commit_resync=1 -> dp_reset high exactly 1 cycle after COMMIT.
//      Commit with resync=0 -> dp_reset never high.
//   6. wr_chan=15 field 2=0x1234 with NCH=16 -> phasewords[255:240]=0x1234 after commit.
//      Writes while PENDING stall (wr_ready=0) and complete after return to IDLE.

Source files
------------

// File: rtl/wave_bank_config.sv
// Shadow/active channel bank with frame-aligned atomic commit and per-channel rate ticks.
// Commit lands one cycle after the accepted frame_tick; host writes stall (wr_ready=0) while a commit is outstanding.
module wave_bank_config #(
  parameter int NCH = 16,
  parameter int W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [3:0]       wr_chan,
  input  logic [1:0]       wr_field,
  input  logic [W-1:0]     wr_data,
  input  logic [NCH-1:0]   ch_enable,
  input  logic             commit_req,
  input  logic             commit_resync,
  input  logic             frame_tick,
  output logic             busy,
  output logic [NCH*W-1:0] amps,
  output logic [NCH*W-1:0] offsets,
  output logic [NCH*W-1:0] phasewords,
  output logic [NCH-1:0]   clks,
  output logic             dp_reset
);

  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;

  state_t       state;
  logic         resync_q;
  logic [W-1:0] amp_s [NCH];
  logic [W-1:0] off_s [NCH];
  logic [W-1:0] pw_s  [NCH];
  logic [W-1:0] div_s [NCH];
  logic [W-1:0] div_a [NCH];
  logic [W-1:0] cnt   [NCH];
  logic         wr_fire;

  assign wr_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  // Channels beyond NCH are accepted but dropped.
  assign wr_fire  = wr_valid && wr_ready && (int'(wr_chan) < NCH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      resync_q   <= 1'b0;
      dp_reset   <= 1'b0;
      amps       <= '0;
      offsets    <= '0;
      phasewords <= '0;
      for (int i = 0; i < NCH; i++) begin
        amp_s[i] <= '0;
        off_s[i] <= '0;
        pw_s[i]  <= '0;
        div_s[i] <= '0;
        div_a[i] <= '0;
      end
    end else begin
      dp_reset <= 1'b0;
      if (wr_fire) begin
        case (wr_field)
          2'd0:    amp_s[wr_chan] <= wr_data;
          2'd1:    off_s[wr_chan] <= wr_data;
          2'd2:    pw_s[wr_chan]  <= wr_data;
          default: div_s[wr_chan] <= wr_data;
        endcase
      end
      case (state)
        IDLE: begin
          // A frame_tick in this same cycle is deliberately not honoured.
          if (commit_req) begin
            state    <= PENDING;
            resync_q <= commit_resync;
          end
        end
        PENDING: begin
          if (frame_tick) state <= COMMIT;
        end
        COMMIT: begin
          for (int i = 0; i < NCH; i++) begin
            amps[i*W +: W]       <= amp_s[i];
            offsets[i*W +: W]    <= off_s[i];
            phasewords[i*W +: W] <= pw_s[i];
            div_a[i]             <= div_s[i];
          end
          dp_reset <= resync_q;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Rate counters restart together with the new divisors on the commit edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clks <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!ch_enable[i] || state == COMMIT) begin
          cnt[i]  <= '0;
          clks[i] <= 1'b0;
        end else if (cnt[i] == div_a[i]) begin
          cnt[i]  <= '0;
          clks[i] <= 1'b1;
        end else begin
          cnt[i]  <= cnt[i] + W'(1);
          clks[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_wave_bank_config.sv
// Directed bench for wave_bank_config: per-cycle vector table plus hand sequences for reset and rate ticks.
module tb_wave_bank_config;

  localparam int NCH = 16;
  localparam int W   = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             wr_valid;
  logic             wr_ready;
  logic [3:0]       wr_chan;
  logic [1:0]       wr_field;
  logic [W-1:0]     wr_data;
  logic [NCH-1:0]   ch_enable;
  logic             commit_req;
  logic             commit_resync;
  logic             frame_tick;
  logic             busy;
  logic [NCH*W-1:0] amps;
  logic [NCH*W-1:0] offsets;
  logic [NCH*W-1:0] phasewords;
  logic [NCH-1:0]   clks;
  logic             dp_reset;

  int checks = 0;
  int errors = 0;

  wave_bank_config #(.NCH(NCH), .W(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chan(wr_chan),
    .wr_field(wr_field), .wr_data(wr_data), .ch_enable(ch_enable),
    .commit_req(commit_req), .commit_resync(commit_resync), .frame_tick(frame_tick),
    .busy(busy), .amps(amps), .offsets(offsets), .phasewords(phasewords),
    .clks(clks), .dp_reset(dp_reset)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  ch;
    logic [1:0]  f;
    logic [15:0] d;
    logic        cr;
    logic        rs;
    logic        ft;
    logic        e_rdy;
    logic        e_busy;
    logic        e_dp;
    logic [15:0] e_amp3;
    logic [15:0] e_pw15;
  } vec_t;

  vec_t vt[23];

  function automatic vec_t mk(input logic v, input logic [3:0] ch, input logic [1:0] f,
                              input logic [15:0] d, input logic cr, input logic rs, input logic ft,
                              input logic e_rdy, input logic e_busy, input logic e_dp,
                              input logic [15:0] e_amp3, input logic [15:0] e_pw15);
    vec_t r;
    r.v = v; r.ch = ch; r.f = f; r.d = d; r.cr = cr; r.rs = rs; r.ft = ft;
    r.e_rdy = e_rdy; r.e_busy = e_busy; r.e_dp = e_dp; r.e_amp3 = e_amp3; r.e_pw15 = e_pw15;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Expected values are the state after the edge that samples the row's inputs.
    //           v  ch  f  data     cr rs ft  rdy bsy dp  amp3     pw15
    vt[0]  = mk(1, 3, 0, 16'h7FFF, 0, 0, 0,  1, 0, 0, 16'h0000, 16'h0000);
    vt[1]  = mk(0, 0, 0, 16'h0000, 0, 0, 0,  1, 0, 0, 16'h0000, 16'h0000);
    vt[2]  = mk(0, 0, 0, 16'h0000, 1, 0, 0,  0, 1, 0, 16'h0000, 16'h0000);
    vt[3]  = mk(0, 0, 0, 16'h0000, 0, 0, 0,  0, 1, 0, 16'h0000, 16'h0000);
    vt[4]  = mk(0, 0, 0, 16'h0000, 1, 0, 0,  0, 1, 0, 16'h0000, 16'h0000);
    vt[5]  = mk(0, 0, 0, 16'h0000, 0, 0, 0,  0, 1, 0, 16'h0000, 16'h0000);
    vt[6]  = mk(0, 0, 0, 16'h0000, 0, 0, 0,  0, 1, 0, 16'h0000, 16'h0000);
    vt[7]  = mk(0, 0, 0, 16'h0000, 0, 0, 1,  0, 1, 0, 16'h0000, 16'h0000);
    vt[8]  = mk(0, 0, 0, 16'h0000, 0, 0, 0,  1, 0, 0, 16'h7FFF, 16'h0000);
    vt[9]  = mk(0, 0, 0, 16'h0000, 0, 0, 0,  1, 0, 0, 16'h7FFF, 16'h0000);
    vt[10] = mk(1, 3, 0, 16'h1111, 1, 1, 1,  0, 1, 0, 16'h7FFF, 16'h0000);
    vt[11] = mk(0, 0, 0, 16'h0000, 0, 0, 0,  0, 1, 0, 16'h7FFF, 16'h0000);
    vt[12] = mk(0, 0, 0, 16'h0000, 0, 0, 1,  0, 1, 0, 16'h7FFF, 16'h0000);
    vt[13] = mk(0, 0, 0, 16'h0000, 0, 0, 0,  1, 0, 1, 16'h1111, 16'h0000);
    vt[14] = mk(0, 0, 0, 16'h0000, 0, 0, 0,  1, 0, 0, 16'h1111, 16'h0000);
    vt[15] = mk(0, 0, 0, 16'h0000, 1, 0, 0,  0, 1, 0, 16'h1111, 16'h0000);
    vt[16] = mk(1, 15, 2, 16'h1234, 0, 0, 0, 0, 1, 0, 16'h1111, 16'h0000);
    vt[17] = mk(1, 15, 2, 16'h1234, 0, 0, 1, 0, 1, 0, 16'h1111, 16'h0000);
    vt[18] = mk(1, 15, 2, 16'h1234, 0, 0, 0, 1, 0, 0, 16'h1111, 16'h0000);
    vt[19] = mk(1, 15, 2, 16'h1234, 0, 0, 0, 1, 0, 0, 16'h1111, 16'h0000);
    vt[20] = mk(0, 0, 0, 16'h0000, 1, 0, 0,  0, 1, 0, 16'h1111, 16'h0000);
    vt[21] = mk(0, 0, 0, 16'h0000, 0, 0, 1,  0, 1, 0, 16'h1111, 16'h0000);
    vt[22] = mk(0, 0, 0, 16'h0000, 0, 0, 0,  1, 0, 0, 16'h1111, 16'h1234);

    reset_n = 1'b0; wr_valid = 1'b0; wr_chan = '0; wr_field = '0; wr_data = '0;
    ch_enable = '0; commit_req = 1'b0; commit_resync = 1'b0; frame_tick = 1'b0;
    repeat (2) tick();
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_amps", 32'(|amps), 32'd0);
    chk("rst_clks", 32'(clks), 32'd0);
    chk("rst_dp_reset", 32'(dp_reset), 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 23; i++) begin
      wr_valid = vt[i].v; wr_chan = vt[i].ch; wr_field = vt[i].f; wr_data = vt[i].d;
      commit_req = vt[i].cr; commit_resync = vt[i].rs; frame_tick = vt[i].ft;
      tick();
      chk($sformatf("v%0d_wr_ready", i), 32'(wr_ready), 32'(vt[i].e_rdy));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
      chk($sformatf("v%0d_dp_reset", i), 32'(dp_reset), 32'(vt[i].e_dp));
      chk($sformatf("v%0d_amp3", i), 32'(amps[63:48]), 32'(vt[i].e_amp3));
      chk($sformatf("v%0d_pw15", i), 32'(phasewords[255:240]), 32'(vt[i].e_pw15));
    end
    wr_valid = 1'b0; commit_req = 1'b0; frame_tick = 1'b0; commit_resync = 1'b0;

    // Asynchronous reset while a commit is pending.
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_wr_ready", 32'(wr_ready), 32'd1);
    chk("midrst_amp3", 32'(amps[63:48]), 32'd0);
    chk("midrst_pw15", 32'(phasewords[255:240]), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Rate ticks: ch0 divisor 3, ch1 divisor 0, resync commit.
    ch_enable = 16'h0003;
    wr_valid = 1'b1; wr_chan = 4'd0; wr_field = 2'd3; wr_data = 16'd3;
    tick();
    wr_valid = 1'b0;
    commit_req = 1'b1; commit_resync = 1'b1;
    tick();
    commit_req = 1'b0; commit_resync = 1'b0; frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      tick();
      chk($sformatf("k%0d_clk0", k), 32'(clks[0]), 32'((k != 0) && (k % 4 == 0)));
      chk($sformatf("k%0d_dp_reset", k), 32'(dp_reset), 32'(k == 0));
      if (k >= 1) chk($sformatf("k%0d_clk1", k), 32'(clks[1]), 32'd1);
    end
    ch_enable = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("off%0d_clks", k), 32'(clks), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
